// File: rtl/spike_window_integrator.sv
`default_nettype none
// ============================================================================
// Module   : spike_window_integrator
// Purpose  : Integrates signed, weighted spikes over a fixed window into a
//            saturating membrane and emits a thresholded decision (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module spike_window_integrator #(
    parameter int N_INPUTS  = 4,
    parameter int WINDOW    = 256,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_INPUTS-1:0]  spikes_in,
    input  logic [N_INPUTS-1:0]  inhibit,
    input  logic [ACC_WIDTH-1:0] threshold,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 fire,
    output logic [ACC_WIDTH-1:0] membrane
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [CW-1:0]        c_window = CW'(WINDOW);
    localparam logic [CW-1:0]        c_cnt_one = CW'(1);
    localparam logic signed [SW-1:0] c_max = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] c_min = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0] c_one = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INTEGRATE = 2'd1,
        S_VALID     = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  membrane_q, membrane_d;
    logic                         fire_q, fire_d;
    logic                         busy_q, busy_d;
    logic                         valid_q, valid_d;

    logic signed [SW-1:0]         delta;
    logic signed [SW-1:0]         sum;
    logic signed [ACC_WIDTH-1:0]  mem_sat;

    // One extra bit of headroom keeps membrane+delta exact before clamping.
    always_comb begin
        delta = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (spikes_in[i]) begin
                if (inhibit[i]) delta = delta - c_one;
                else            delta = delta + c_one;
            end
        end
        sum = {membrane_q[ACC_WIDTH-1], membrane_q} + delta;
        if (sum > c_max)      mem_sat = c_max[ACC_WIDTH-1:0];
        else if (sum < c_min) mem_sat = c_min[ACC_WIDTH-1:0];
        else                  mem_sat = sum[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        membrane_d = membrane_q;
        fire_d     = fire_q;
        case (state_q)
            S_IDLE: begin
                membrane_d = '0;
                cnt_d      = '0;
                if (start) state_d = S_INTEGRATE;
            end
            S_INTEGRATE: begin
                membrane_d = mem_sat;
                cnt_d      = cnt_q + c_cnt_one;
                if (cnt_d == c_window) begin
                    fire_d  = (mem_sat >= $signed(threshold));
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (result_ready) begin
                    state_d    = S_IDLE;
                    membrane_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                membrane_d = '0;
                cnt_d      = '0;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            membrane_q <= '0;
            fire_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            membrane_q <= membrane_d;
            fire_q     <= fire_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign fire         = fire_q;
    assign membrane     = membrane_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_window_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_window_integrator
// Purpose  : Self-checking bench; two DUT configurations against a clamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_window_integrator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        result_ready = 1'b0;
    logic [3:0]  spikes_in = '0;
    logic [3:0]  inhibit = '0;
    logic [15:0] threshold = '0;
    int          sel = 0;

    logic        start_a, start_b, rdy_a, rdy_b;
    logic        busy_a, busy_b, valid_a, valid_b, fire_a, fire_b;
    logic [15:0] mem_a;
    logic [7:0]  mem_b;
    int          m_busy, m_valid, m_fire, m_mem;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign start_a = start & (sel == 0);
    assign start_b = start & (sel != 0);
    assign rdy_a   = result_ready & (sel == 0);
    assign rdy_b   = result_ready & (sel != 0);

    spike_window_integrator #(.N_INPUTS(4), .WINDOW(16), .ACC_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .spikes_in(spikes_in),
        .inhibit(inhibit), .threshold(threshold), .busy(busy_a),
        .result_valid(valid_a), .result_ready(rdy_a), .fire(fire_a),
        .membrane(mem_a)
    );

    spike_window_integrator #(.N_INPUTS(4), .WINDOW(64), .ACC_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .spikes_in(spikes_in),
        .inhibit(inhibit), .threshold(threshold[7:0]), .busy(busy_b),
        .result_valid(valid_b), .result_ready(rdy_b), .fire(fire_b),
        .membrane(mem_b)
    );

    always_comb begin
        m_busy  = (sel != 0) ? int'(busy_b)  : int'(busy_a);
        m_valid = (sel != 0) ? int'(valid_b) : int'(valid_a);
        m_fire  = (sel != 0) ? int'(fire_b)  : int'(fire_a);
        m_mem   = (sel != 0) ? int'($signed(mem_b)) : int'($signed(mem_a));
    end

    typedef struct {
        int    s;
        int    thr;
        int    mode;
        int    exp_mem;
        int    exp_fire;
        int    hold;
        string name;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int delta_of(input logic [3:0] sp, input logic [3:0] inh);
        int d = 0;
        for (int i = 0; i < 4; i++)
            if (sp[i]) d += inh[i] ? -1 : 1;
        return d;
    endfunction

    function automatic int clampv(input int v, input int aw);
        int hi = (1 << (aw - 1)) - 1;
        int lo = -(1 << (aw - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic drive_pattern(input int mode, input int k, input int win);
        case (mode)
            1: begin spikes_in = 4'hF; inhibit = 4'h0; end
            2: begin spikes_in = 4'hF; inhibit = 4'hF; end
            3: begin spikes_in = 4'hF; inhibit = 4'b0011; end
            4: begin spikes_in = 4'hF; inhibit = (k <= win / 2) ? 4'h0 : 4'hF; end
            default: begin spikes_in = 4'($urandom); inhibit = 4'($urandom); end
        endcase
    endtask

    // Runs one window; pulse_at>0 pulses start on that INTEGRATE cycle.
    task automatic run_window(input int s, input int thr, input int mode,
                              input int pulse_at, output int m_final);
        int win = (s != 0) ? 64 : 16;
        int aw  = (s != 0) ? 8 : 16;
        int m   = 0;
        sel = s;
        threshold = 16'(thr);
        spikes_in = 4'hF;
        inhibit = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", m_busy, 1);
        check("start_mem", m_mem, 0);
        for (int k = 1; k <= win; k++) begin
            drive_pattern(mode, k, win);
            if (k == pulse_at) start = 1'b1;
            m = clampv(m + delta_of(spikes_in, inhibit), aw);
            tick();
            start = 1'b0;
            if (k < win) begin
                check("int_valid", m_valid, 0);
                check("int_busy", m_busy, 1);
                check("int_mem", m_mem, m);
            end
        end
        spikes_in = 4'($urandom);
        check("res_valid", m_valid, 1);
        check("res_busy", m_busy, 1);
        check("res_mem", m_mem, m);
        check("res_fire", m_fire, (m >= thr) ? 1 : 0);
        m_final = m;
    endtask

    task automatic handshake(input int hold, input bit pulse, input int exp_m, input int exp_f);
        for (int i = 0; i < hold; i++) begin
            result_ready = 1'b0;
            start = pulse && (i == hold / 2);
            spikes_in = 4'($urandom);
            tick();
            start = 1'b0;
            check("bp_valid", m_valid, 1);
            check("bp_mem", m_mem, exp_m);
            check("bp_fire", m_fire, exp_f);
        end
        result_ready = 1'b1;
        start = pulse;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check("hs_valid", m_valid, 0);
        check("hs_busy", m_busy, 0);
        check("hs_mem", m_mem, 0);
        check("hs_fire", m_fire, exp_f);
        tick();
        check("idle_busy", m_busy, 0);
        check("idle_fire", m_fire, exp_f);
    endtask

    vec_t vecs[7];
    int   m;
    int   f;
    int   thr;

    initial begin
        vecs[0] = '{0,   50, 1,   64, 1, 0,  "all_exc_w16"};
        vecs[1] = '{0,    0, 3,    0, 1, 2,  "balanced_thr0"};
        vecs[2] = '{0,    1, 3,    0, 0, 1,  "balanced_thr1"};
        vecs[3] = '{1,  127, 1,  127, 1, 10, "sat_hi"};
        vecs[4] = '{1, -127, 2, -128, 0, 3,  "sat_lo"};
        vecs[5] = '{1,    0, 4,   -1, 0, 0,  "off_rail"};
        vecs[6] = '{0,  -64, 2,  -64, 1, 1,  "all_inh_w16"};

        repeat (3) tick();
        rst = 1'b0;
        sel = 0; #1;
        check("rst_a_busy", m_busy, 0);
        check("rst_a_valid", m_valid, 0);
        check("rst_a_mem", m_mem, 0);
        check("rst_a_fire", m_fire, 0);
        sel = 1; #1;
        check("rst_b_busy", m_busy, 0);
        check("rst_b_valid", m_valid, 0);
        check("rst_b_mem", m_mem, 0);
        check("rst_b_fire", m_fire, 0);

        for (int v = 0; v < 7; v++) begin
            run_window(vecs[v].s, vecs[v].thr, vecs[v].mode, 0, m);
            check({vecs[v].name, "_mem"}, m_mem, vecs[v].exp_mem);
            check({vecs[v].name, "_fire"}, m_fire, vecs[v].exp_fire);
            handshake(vecs[v].hold, 1'b0, vecs[v].exp_mem, vecs[v].exp_fire);
        end

        // start pulses in INTEGRATE, VALID and the handshake cycle are ignored
        run_window(0, 10, 0, 3, m);
        handshake(4, 1'b1, m, (m >= 10) ? 1 : 0);

        // reset at INTEGRATE cycle 5 with fire previously 1
        run_window(0, 0, 1, 0, m);
        handshake(0, 1'b0, 64, 1);
        sel = 0;
        threshold = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_pattern(1, k, 16);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", m_busy, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_mem", m_mem, 0);
        check("mid_rst_fire", m_fire, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_valid", m_valid, 0);
        end
        run_window(0, 30, 1, 0, m);
        check("post_rst_mem", m_mem, 64);
        handshake(1, 1'b0, 64, 1);

        for (int r = 0; r < 8; r++) begin
            if ((r % 2) != 0) thr = int'($urandom_range(255)) - 128;
            else              thr = int'($urandom_range(40)) - 20;
            run_window(r % 2, thr, 0, 0, m);
            f = (m >= thr) ? 1 : 0;
            handshake(int'($urandom_range(3)), 1'b0, m, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
